// File: rtl/twiddle64_part2_if.sv
// Handshake and data bundle between twiddle64_part1 and twiddle64_part2.
// The ovf flag is present only when TWIDDLE64_SAT_EN is defined.
interface twiddle64_part2_if #(
  parameter int DATA_WIDTH = 14
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_sof;
  logic signed [DATA_WIDTH:0]   tmp_rere;
  logic signed [DATA_WIDTH:0]   tmp_imim;
  logic signed [DATA_WIDTH:0]   tmp_reim;
  logic signed [DATA_WIDTH:0]   tmp_imre;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] dout_real;
  logic signed [DATA_WIDTH-1:0] dout_imag;
  logic                         out_last;
`ifdef TWIDDLE64_SAT_EN
  logic                         ovf;
`endif

  modport master (
    output in_valid, in_sof, tmp_rere, tmp_imim, tmp_reim, tmp_imre, out_ready,
    input  in_ready, out_valid, dout_real, dout_imag, out_last
`ifdef TWIDDLE64_SAT_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, in_sof, tmp_rere, tmp_imim, tmp_reim, tmp_imre, out_ready,
    output in_ready, out_valid, dout_real, dout_imag, out_last
`ifdef TWIDDLE64_SAT_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/twiddle64_part2.sv
// Twiddle completion stage: combine partial products, rotate by (-j)^q per 64-point
// index, round and saturate (TWIDDLE64_SAT_EN) or wrap. Two-stage stallable pipeline.
module twiddle64_part2 #(
  parameter int DATA_WIDTH = 14,
  parameter int MIRROR     = 0,
  parameter int SHIFT      = 1
) (
  input logic              clk,
  input logic              rst_n,
  twiddle64_part2_if.slave bus
);

  localparam int W1 = DATA_WIDTH + 2;
  localparam int W2 = DATA_WIDTH + 3;
  localparam logic signed [W2-1:0] RND_HALF = W2'(2 ** (SHIFT - 1));
`ifdef TWIDDLE64_SAT_EN
  localparam logic signed [W2-1:0] SAT_MAX = W2'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [W2-1:0] SAT_MIN = W2'(-(2 ** (DATA_WIDTH - 1)));
`endif

  logic                         en;
  logic                         accept;
  logic [5:0]                   idx;
  logic [5:0]                   tag;
  logic signed [W1-1:0]         rere_x, imim_x, reim_x, imre_x;
  logic signed [W1-1:0]         comb_re, comb_im;
  logic                         s1_valid;
  logic                         s1_last;
  logic [1:0]                   s1_q;
  logic signed [W1-1:0]         s1_re, s1_im;
  logic signed [W2-1:0]         ext_re, ext_im, rot_re, rot_im, rnd_re, rnd_im;
  logic signed [DATA_WIDTH-1:0] res_re, res_im;
`ifdef TWIDDLE64_SAT_EN
  logic                         clip_re, clip_im;
`endif

  // Whole pipeline freezes while the output beat is held by downstream.
  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;
  assign accept       = bus.in_valid && en;
  assign tag          = bus.in_sof ? 6'd0 : idx;

  assign rere_x = W1'(bus.tmp_rere);
  assign imim_x = W1'(bus.tmp_imim);
  assign reim_x = W1'(bus.tmp_reim);
  assign imre_x = W1'(bus.tmp_imre);

  generate
    if (MIRROR != 0) begin : g_mirror
      assign comb_re = reim_x + imre_x;
      assign comb_im = imim_x - rere_x;
    end else begin : g_direct
      assign comb_re = rere_x + imim_x;
      assign comb_im = imre_x - reim_x;
    end
  endgenerate

  // One extra bit of headroom so negating the most negative value cannot overflow.
  assign ext_re = W2'(s1_re);
  assign ext_im = W2'(s1_im);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    rot_re = ext_re;
    rot_im = ext_im;
    case (s1_q)
      2'd1:    begin rot_re = ext_im;  rot_im = -ext_re; end
      2'd2:    begin rot_re = -ext_re; rot_im = -ext_im; end
      2'd3:    begin rot_re = -ext_im; rot_im = ext_re;  end
      default: begin rot_re = ext_re;  rot_im = ext_im;  end
    endcase
  end

  assign rnd_re = (rot_re + RND_HALF) >>> SHIFT;
  assign rnd_im = (rot_im + RND_HALF) >>> SHIFT;

`ifdef TWIDDLE64_SAT_EN
  always_comb begin
    clip_re = 1'b0;
    res_re  = rnd_re[DATA_WIDTH-1:0];
    if (rnd_re > SAT_MAX) begin
      res_re  = SAT_MAX[DATA_WIDTH-1:0];
      clip_re = 1'b1;
    end else if (rnd_re < SAT_MIN) begin
      res_re  = SAT_MIN[DATA_WIDTH-1:0];
      clip_re = 1'b1;
    end
  end

  always_comb begin
    clip_im = 1'b0;
    res_im  = rnd_im[DATA_WIDTH-1:0];
    if (rnd_im > SAT_MAX) begin
      res_im  = SAT_MAX[DATA_WIDTH-1:0];
      clip_im = 1'b1;
    end else if (rnd_im < SAT_MIN) begin
      res_im  = SAT_MIN[DATA_WIDTH-1:0];
      clip_im = 1'b1;
    end
  end
`else
  // Two's-complement wrap: the upper bits are intentionally discarded.
  assign res_re = rnd_re[DATA_WIDTH-1:0];
  assign res_im = rnd_im[DATA_WIDTH-1:0];
  wire unused_hi_bits = ^{rnd_re[W2-1:DATA_WIDTH], rnd_im[W2-1:DATA_WIDTH]};
`endif

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      idx           <= 6'd0;
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_q          <= 2'd0;
      s1_re         <= '0;
      s1_im         <= '0;
      bus.out_valid <= 1'b0;
      bus.dout_real <= '0;
      bus.dout_imag <= '0;
      bus.out_last  <= 1'b0;
`ifdef TWIDDLE64_SAT_EN
      bus.ovf       <= 1'b0;
`endif
    end else if (en) begin
      if (accept) begin
        idx <= bus.in_sof ? 6'd1 : idx + 6'd1;
      end
      s1_valid <= bus.in_valid;
      s1_re    <= comb_re;
      s1_im    <= comb_im;
      s1_q     <= tag[5:4];
      s1_last  <= (tag == 6'd63);

      bus.out_valid <= s1_valid;
      bus.out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        bus.dout_real <= res_re;
        bus.dout_imag <= res_im;
      end
`ifdef TWIDDLE64_SAT_EN
      if (s1_valid && (clip_re || clip_im)) begin
        bus.ovf <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_twiddle64_part2.sv
// Randomised self-checking bench for twiddle64_part2 with three parameter sets
// sharing one stimulus stream; optional TWIDDLE64_SAT_EN selects saturation checks.
module tb_twiddle64_part2;

  localparam int DW   = 14;
  localparam int IW   = DW + 1;
  localparam int NCFG = 3;
  localparam int CFG_MIRROR [NCFG] = '{0, 1, 0};
  localparam int CFG_SHIFT  [NCFG] = '{1, 1, 3};

  typedef struct {
    int re;
    int im;
    bit last;
    bit clip;
    int acc_cyc;
    bit seen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  twiddle64_part2_if #(.DATA_WIDTH(DW)) b0 ();
  twiddle64_part2_if #(.DATA_WIDTH(DW)) b1 ();
  twiddle64_part2_if #(.DATA_WIDTH(DW)) b2 ();

  assign b1.in_valid = b0.in_valid;
  assign b1.in_sof   = b0.in_sof;
  assign b1.tmp_rere = b0.tmp_rere;
  assign b1.tmp_imim = b0.tmp_imim;
  assign b1.tmp_reim = b0.tmp_reim;
  assign b1.tmp_imre = b0.tmp_imre;
  assign b1.out_ready = b0.out_ready;
  assign b2.in_valid = b0.in_valid;
  assign b2.in_sof   = b0.in_sof;
  assign b2.tmp_rere = b0.tmp_rere;
  assign b2.tmp_imim = b0.tmp_imim;
  assign b2.tmp_reim = b0.tmp_reim;
  assign b2.tmp_imre = b0.tmp_imre;
  assign b2.out_ready = b0.out_ready;

  twiddle64_part2 #(.DATA_WIDTH(DW), .MIRROR(0), .SHIFT(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  twiddle64_part2 #(.DATA_WIDTH(DW), .MIRROR(1), .SHIFT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  twiddle64_part2 #(.DATA_WIDTH(DW), .MIRROR(0), .SHIFT(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic [NCFG-1:0]     ov_v, ov_last, ir;
  logic signed [DW-1:0] a_re [NCFG];
  logic signed [DW-1:0] a_im [NCFG];
  assign ov_v    = {b2.out_valid, b1.out_valid, b0.out_valid};
  assign ov_last = {b2.out_last, b1.out_last, b0.out_last};
  assign ir      = {b2.in_ready, b1.in_ready, b0.in_ready};
  assign a_re[0] = b0.dout_real;
  assign a_re[1] = b1.dout_real;
  assign a_re[2] = b2.dout_real;
  assign a_im[0] = b0.dout_imag;
  assign a_im[1] = b1.dout_imag;
  assign a_im[2] = b2.dout_imag;
`ifdef TWIDDLE64_SAT_EN
  logic [NCFG-1:0] ovf_v;
  assign ovf_v = {b2.ovf, b1.ovf, b0.ovf};
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Fit a rounded value into DW bits: clamp when saturating, otherwise wrap.
  function automatic int fit(input int v, output bit clip);
    int hi = (1 << (DW - 1)) - 1;
    int lo = -(1 << (DW - 1));
    int m  = 1 << DW;
    clip = 1'b0;
`ifdef TWIDDLE64_SAT_EN
    if (v > hi) begin v = hi; clip = 1'b1; end
    if (v < lo) begin v = lo; clip = 1'b1; end
`else
    v = ((v % m) + m) % m;
    if (v > hi) v -= m;
`endif
    return v;
  endfunction

  // Complex product, times (-j)^(tag/16), scaled by 2^-shift with round-half-up.
  function automatic exp_t model(input int rr, input int ii, input int ri, input int iq,
                                 input int tag, input int mirror, input int shift);
    exp_t e;
    int re, im, t;
    bit c1, c2;
    re = mirror ? ri + iq : rr + ii;
    im = mirror ? ii - rr : iq - ri;
    for (int q = 0; q < tag / 16; q++) begin
      t  = re;
      re = im;
      im = -t;
    end
    re = (re + (1 << (shift - 1))) >>> shift;
    im = (im + (1 << (shift - 1))) >>> shift;
    e.re      = fit(re, c1);
    e.im      = fit(im, c2);
    e.clip    = c1 | c2;
    e.last    = (tag == 63);
    e.acc_cyc = 0;
    e.seen    = 1'b0;
    return e;
  endfunction

  exp_t expq [NCFG][$];
  bit   mov [NCFG];
  int   cyc = 0;
  int   stall_cyc = -10;
  int   midx = 0;
  bit   mon_en = 1'b0;

  // Dut0 / dut1 outputs captured in handshake order for literal checks.
  int hs_n = 0;
  int last_cnt = 0;
  int cap_re [256];
  int cap_im [256];
  int cap_last [256];
  int cap_mre [256];
  int cap_mim [256];
  int hs_m = 0;

  always @(negedge clk) begin
    automatic exp_t e;
    automatic exp_t n;
    automatic int   tg;
    if (mon_en) begin
      cyc++;
      for (int k = 0; k < NCFG; k++) begin
        if (ov_v[k]) begin
          if (expq[k].size() == 0) begin
            check($sformatf("unexpected beat cfg%0d", k), 1, 0);
          end else begin
            e = expq[k][0];
            if (!e.seen) begin
              if (stall_cyc < e.acc_cyc)
                check($sformatf("latency cfg%0d", k), cyc - e.acc_cyc, 2);
              expq[k][0].seen = 1'b1;
            end
            if (e.clip) mov[k] = 1'b1;
            check($sformatf("dout_real cfg%0d", k), int'(a_re[k]), e.re);
            check($sformatf("dout_imag cfg%0d", k), int'(a_im[k]), e.im);
            check($sformatf("out_last cfg%0d", k), int'(ov_last[k]), int'(e.last));
            if (b0.out_ready) begin
              void'(expq[k].pop_front());
              if (k == 0 && hs_n < 256) begin
                cap_re[hs_n]   = int'(a_re[0]);
                cap_im[hs_n]   = int'(a_im[0]);
                cap_last[hs_n] = int'(ov_last[0]);
                hs_n++;
                if (ov_last[0]) last_cnt++;
              end
              if (k == 1 && hs_m < 256) begin
                cap_mre[hs_m] = int'(a_re[1]);
                cap_mim[hs_m] = int'(a_im[1]);
                hs_m++;
              end
            end
          end
        end
`ifdef TWIDDLE64_SAT_EN
        check($sformatf("ovf cfg%0d", k), int'(ovf_v[k]), int'(mov[k]));
`endif
      end
      check("in_ready", int'(ir[0]), int'(!(ov_v[0] && !b0.out_ready)));
      if (ov_v[0] && !b0.out_ready) stall_cyc = cyc;

      if (!rst_n) begin
        for (int k = 0; k < NCFG; k++) begin
          expq[k].delete();
          mov[k] = 1'b0;
        end
        midx = 0;
      end else if (b0.in_valid && ir[0]) begin
        tg   = b0.in_sof ? 0 : midx;
        midx = b0.in_sof ? 1 : (midx + 1) % 64;
        for (int k = 0; k < NCFG; k++) begin
          n = model(int'(b0.tmp_rere), int'(b0.tmp_imim), int'(b0.tmp_reim),
                    int'(b0.tmp_imre), tg, CFG_MIRROR[k], CFG_SHIFT[k]);
          n.acc_cyc = cyc;
          expq[k].push_back(n);
        end
      end
    end
  end

  task automatic beat(input bit v, input bit sof, input int rr, input int ii,
                      input int ri, input int iq);
    b0.in_valid = v;
    b0.in_sof   = sof;
    b0.tmp_rere = IW'(rr);
    b0.tmp_imim = IW'(ii);
    b0.tmp_reim = IW'(ri);
    b0.tmp_imre = IW'(iq);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic clear_caps();
    hs_n = 0;
    hs_m = 0;
    last_cnt = 0;
  endtask

  function automatic int rnd_in();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  task automatic check_outputs_reset(input string tagname);
    @(negedge clk);
    #1;
    check({tagname, " out_valid"}, int'(b0.out_valid), 0);
    check({tagname, " in_ready"}, int'(b0.in_ready), 1);
    check({tagname, " dout_real"}, int'(b0.dout_real), 0);
    check({tagname, " dout_imag"}, int'(b0.dout_imag), 0);
    check({tagname, " out_last"}, int'(b0.out_last), 0);
`ifdef TWIDDLE64_SAT_EN
    check({tagname, " ovf"}, int'(b0.ovf), 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b0;
    b0.in_sof    = 1'b0;
    b0.tmp_rere  = '0;
    b0.tmp_imim  = '0;
    b0.tmp_reim  = '0;
    b0.tmp_imre  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    check_outputs_reset("reset");

    // Full frame of constant input: one rotation per quadrant.
    clear_caps();
    for (int i = 0; i < 64; i++) beat(1'b1, i == 0, 1000, 200, 300, 800);
    idle(4);
    check("frame beats", hs_n, 64);
    check("beat0 re", cap_re[0], 600);
    check("beat0 im", cap_im[0], 250);
    check("beat15 re", cap_re[15], 600);
    check("beat16 re", cap_re[16], 250);
    check("beat16 im", cap_im[16], -600);
    check("beat32 re", cap_re[32], -600);
    check("beat47 im", cap_im[47], -250);
    check("beat48 re", cap_re[48], -250);
    check("beat63 im", cap_im[63], 600);
    check("beat62 last", cap_last[62], 0);
    check("beat63 last", cap_last[63], 1);
    check("frame last count", last_cnt, 1);
    check("mirror beat0 re", cap_mre[0], 550);
    check("mirror beat0 im", cap_mim[0], -400);

    // Five-cycle downstream stall in the middle of a stream.
    clear_caps();
    for (int i = 0; i < 24; i++) begin
      b0.out_ready = !(i >= 8 && i < 13);
      if (i >= 8 && i < 13) begin
        #1;
        check("stall in_ready", int'(b0.in_ready), 0);
      end
      beat(1'b1, i == 0, int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)),
           int'($urandom_range(0, 2000)), int'($urandom_range(0, 2000)));
    end
    b0.out_ready = 1'b1;
    idle(4);
    check("stall beats", hs_n, 19);

    // Overflow of the combined real part.
    clear_caps();
    beat(1'b1, 1'b1, 16383, 16383, 0, 0);
    idle(4);
`ifdef TWIDDLE64_SAT_EN
    check("sat dout_real", cap_re[0], 8191);
    check("ovf set", int'(b0.ovf), 1);
    beat(1'b1, 1'b1, 10, 10, 0, 0);
    idle(4);
    check("ovf sticky", int'(b0.ovf), 1);
`else
    check("wrap dout_real", cap_re[0], -1);
`endif

    // Frame restart at index 20.
    clear_caps();
    for (int i = 0; i < 84; i++) beat(1'b1, i == 0 || i == 20, 1000, 200, 300, 800);
    idle(4);
    check("restart beat19 re", cap_re[19], 250);
    check("restart beat20 re", cap_re[20], 600);
    check("restart beat20 im", cap_im[20], 250);
    check("restart last at 83", cap_last[83], 1);
    check("restart last count", last_cnt, 1);

    // Reset with beats in flight at indices 16 and 17.
    for (int i = 0; i < 18; i++) beat(1'b1, i == 0, 1000, 200, 300, 800);
    b0.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs_reset("mid reset");
    clear_caps();
    beat(1'b1, 1'b0, 1000, 200, 300, 800);
    idle(4);
    check("post reset beats", hs_n, 1);
    check("post reset re", cap_re[0], 600);
    check("post reset im", cap_im[0], 250);

    // Randomised traffic with random backpressure and one reset.
    for (int i = 0; i < 3000; i++) begin
      b0.out_ready = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        beat(1'b1, 1'b0, rnd_in(), rnd_in(), rnd_in(), rnd_in());
        rst_n = 1'b1;
      end else begin
        beat($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
             rnd_in(), rnd_in(), rnd_in(), rnd_in());
      end
    end
    b0.out_ready = 1'b1;
    idle(6);
    for (int k = 0; k < NCFG; k++)
      check($sformatf("drained cfg%0d", k), expq[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
